wb_resp_queue: RTL and testbench

- Branch-killable FIFO directly downstream of the 2-input writeback response arbiter.
- Accepts the arbiter's response packet (uop fields, 65-bit data, predicated flag, fflags) and holds it until the register-file writeback port takes it.
- Applies branch resolution every cycle:
  - clears resolved bits from each entry's br_mask;
  - kills entries that depend on a mispredicted branch.
- Decouples arbiter grant timing from regfile port backpressure.

---
 rtl/boom_wb_pkg.sv | 33 +++
 rtl/wb_resp_queue.sv | 109 ++++++++++
 tb/tb_wb_resp_queue.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/boom_wb_pkg.sv
// Shared types for the writeback response path: response packet layout and branch-kill helper.
package boom_wb_pkg;

    localparam int BR_W      = 12;
    localparam int UOPC_W    = 7;
    localparam int ROB_W     = 6;
    localparam int PREG_W    = 7;
    localparam int DATA_W    = 65;
    localparam int WB_RESP_W = 119;

    typedef struct packed {
        logic [UOPC_W-1:0] uopc;
        logic [BR_W-1:0]   br_mask;
        logic [ROB_W-1:0]  rob_idx;
        logic [3:0]        stq_idx;
        logic [PREG_W-1:0] pdst;
        logic              is_amo;
        logic              uses_stq;
        logic [1:0]        dst_rtype;
        logic              fp_val;
        logic [DATA_W-1:0] data;
        logic              predicated;
        logic              fflags_valid;
        logic [ROB_W-1:0]  fflags_rob_idx;
        logic [4:0]        fflags_flags;
    } wb_resp_t;

    function automatic logic kill_check(input logic [BR_W-1:0] mask,
                                        input logic [BR_W-1:0] mispredict);
        return |(mask & mispredict);
    endfunction

endpackage

// File: rtl/wb_resp_queue.sv
// Branch-killable response FIFO between the writeback arbiter and the regfile write port.
module wb_resp_queue #(
    parameter int ENTRIES = 4,
    parameter int BR_W    = 12
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              io_enq_valid,
    output logic                              io_enq_ready,
    input  logic [boom_wb_pkg::WB_RESP_W-1:0] io_enq_bits,
    output logic                              io_deq_valid,
    input  logic                              io_deq_ready,
    output logic [boom_wb_pkg::WB_RESP_W-1:0] io_deq_bits,
    input  logic [BR_W-1:0]                   io_brupdate_resolve_mask,
    input  logic [BR_W-1:0]                   io_brupdate_mispredict_mask,
    input  logic                              io_flush,
    output logic [$clog2(ENTRIES):0]          io_count
);
    import boom_wb_pkg::*;

    localparam int PTR_W = $clog2(ENTRIES);
    localparam int CNT_W = PTR_W + 1;

    wb_resp_t               payload_q [ENTRIES];
    wb_resp_t               payload_d [ENTRIES];
    logic [ENTRIES-1:0]     valid_q, valid_d;
    logic [PTR_W-1:0]       enq_ptr_q, enq_ptr_d;
    logic [PTR_W-1:0]       deq_ptr_q, deq_ptr_d;
    logic                   maybe_full_q, maybe_full_d;

    wb_resp_t               enq_pkt;
    wb_resp_t               head_pkt;
    logic                   ptr_match, full, empty;
    logic                   do_enq, do_deq;

    assign enq_pkt   = wb_resp_t'(io_enq_bits);
    assign ptr_match = (enq_ptr_q == deq_ptr_q);
    assign full      = ptr_match & maybe_full_q;
    assign empty     = ptr_match & ~maybe_full_q;

    assign io_enq_ready = ~full;
    assign do_enq       = io_enq_valid & ~full;

    always_comb begin
        head_pkt         = payload_q[deq_ptr_q];
        head_pkt.br_mask = head_pkt.br_mask & ~io_brupdate_resolve_mask;
    end

    assign io_deq_bits  = head_pkt;
    assign io_deq_valid = ~empty & ~io_flush & valid_q[deq_ptr_q]
                        & ~kill_check(payload_q[deq_ptr_q].br_mask, io_brupdate_mispredict_mask);

    // Killed holes at the head retire without waiting for the writeback port.
    assign do_deq = ~empty & (~valid_q[deq_ptr_q] | (io_deq_valid & io_deq_ready));

    assign io_count = full ? CNT_W'(ENTRIES) : {1'b0, enq_ptr_q - deq_ptr_q};

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_slot
            logic wr_en;
            assign wr_en = do_enq & (enq_ptr_q == PTR_W'(gi));

            always_comb begin
                payload_d[gi]         = wr_en ? enq_pkt : payload_q[gi];
                payload_d[gi].br_mask = payload_d[gi].br_mask & ~io_brupdate_resolve_mask;
            end

            assign valid_d[gi] = io_flush ? 1'b0 :
                                 wr_en    ? ~kill_check(enq_pkt.br_mask, io_brupdate_mispredict_mask) :
                                            valid_q[gi] & ~kill_check(payload_q[gi].br_mask,
                                                                      io_brupdate_mispredict_mask);
        end
    endgenerate

    always_comb begin
        enq_ptr_d    = enq_ptr_q + PTR_W'(do_enq);
        deq_ptr_d    = deq_ptr_q + PTR_W'(do_deq);
        maybe_full_d = maybe_full_q;
        if (do_enq != do_deq) begin
            maybe_full_d = do_enq;
        end
        if (io_flush) begin
            enq_ptr_d    = '0;
            deq_ptr_d    = '0;
            maybe_full_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            enq_ptr_q    <= '0;
            deq_ptr_q    <= '0;
            maybe_full_q <= 1'b0;
            valid_q      <= '0;
        end else begin
            enq_ptr_q    <= enq_ptr_d;
            deq_ptr_q    <= deq_ptr_d;
            maybe_full_q <= maybe_full_d;
            valid_q      <= valid_d;
        end
    end

    // Payload carries no reset; liveness is tracked solely by valid_q and the pointers.
    always_ff @(posedge clock) begin
        payload_q <= payload_d;
    end

endmodule

// File: tb/tb_wb_resp_queue.sv
// Directed self-checking bench for wb_resp_queue.
module tb_wb_resp_queue;
    import boom_wb_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              io_enq_valid;
    logic              io_enq_ready;
    wb_resp_t          enq_s;
    logic              io_deq_valid;
    logic              io_deq_ready;
    logic [118:0]      io_deq_bits;
    logic [11:0]       resolve_mask;
    logic [11:0]       mispredict_mask;
    logic              io_flush;
    logic [2:0]        io_count;

    int checks   = 0;
    int failures = 0;

    wb_resp_queue #(.ENTRIES(4), .BR_W(12)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .io_enq_valid                (io_enq_valid),
        .io_enq_ready                (io_enq_ready),
        .io_enq_bits                 (enq_s),
        .io_deq_valid                (io_deq_valid),
        .io_deq_ready                (io_deq_ready),
        .io_deq_bits                 (io_deq_bits),
        .io_brupdate_resolve_mask    (resolve_mask),
        .io_brupdate_mispredict_mask (mispredict_mask),
        .io_flush                    (io_flush),
        .io_count                    (io_count)
    );

    always #5 clock = ~clock;

    function automatic wb_resp_t mk(input logic [7:0] d, input logic [11:0] br);
        wb_resp_t s;
        s                = '0;
        s.uopc           = 7'h15;
        s.br_mask        = br;
        s.rob_idx        = d[5:0];
        s.stq_idx        = 4'h9;
        s.pdst           = 7'h2a;
        s.is_amo         = 1'b1;
        s.dst_rtype      = 2'b01;
        s.data           = {57'h1_0000_0000_0000_00, d};
        s.predicated     = d[0];
        s.fflags_valid   = 1'b1;
        s.fflags_rob_idx = 6'h33;
        s.fflags_flags   = 5'h13;
        return s;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset           = 1'b0;
        io_enq_valid    = 1'b1;
        enq_s           = mk(8'h99, 12'h0);
        io_deq_ready    = 1'b0;
        resolve_mask    = '0;
        mispredict_mask = '0;
        io_flush        = 1'b0;
        #1;
        chk("rst_enq_ready", 128'(io_enq_ready), 128'(1));
        chk("rst_deq_valid", 128'(io_deq_valid), 128'(0));
        chk("rst_count",     128'(io_count),     128'(0));
        tick();
        tick();
        chk("rst_hold_count", 128'(io_count), 128'(0));

        // Release reset and fill four slots.
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            enq_s = mk(8'(i), 12'h0);
            tick();
        end
        #1;
        chk("full_count",     128'(io_count),     128'(4));
        chk("full_enq_ready", 128'(io_enq_ready), 128'(0));
        enq_s = mk(8'h55, 12'h0);
        tick();
        chk("full_no_enq_count", 128'(io_count), 128'(4));
        io_enq_valid = 1'b0;
        io_deq_ready = 1'b1;
        #1;
        chk("full_ready_indep", 128'(io_enq_ready), 128'(0));
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain%0d_valid", i), 128'(io_deq_valid), 128'(1));
            chk($sformatf("drain%0d_bits", i),  128'(io_deq_bits),  128'(mk(8'(i), 12'h0)));
            tick();
        end
        chk("drained_valid", 128'(io_deq_valid), 128'(0));
        chk("drained_count", 128'(io_count),     128'(0));
        io_deq_ready = 1'b0;

        // Mispredict kills A at the head; hole drains alone, B follows.
        io_enq_valid = 1'b1;
        enq_s = mk(8'h0a, 12'h001);
        tick();
        enq_s = mk(8'h0b, 12'h002);
        tick();
        io_enq_valid = 1'b0;
        #1;
        chk("kill_head_before", 128'(io_deq_valid), 128'(1));
        mispredict_mask = 12'h001;
        #1;
        chk("kill_head_comb", 128'(io_deq_valid), 128'(0));
        tick();
        mispredict_mask = '0;
        #1;
        chk("kill_hole_valid", 128'(io_deq_valid), 128'(0));
        chk("kill_hole_count", 128'(io_count),     128'(2));
        tick();
        chk("kill_b_count", 128'(io_count),     128'(1));
        chk("kill_b_valid", 128'(io_deq_valid), 128'(1));
        chk("kill_b_bits",  128'(io_deq_bits),  128'(mk(8'h0b, 12'h002)));
        io_deq_ready = 1'b1;
        tick();
        io_deq_ready = 1'b0;
        chk("kill_empty_count", 128'(io_count), 128'(0));

        // Resolve arriving with the enqueue clears the bit on the way in.
        io_enq_valid = 1'b1;
        enq_s        = mk(8'h0c, 12'h00c);
        resolve_mask = 12'h004;
        tick();
        io_enq_valid = 1'b0;
        resolve_mask = '0;
        #1;
        chk("resolve_valid", 128'(io_deq_valid), 128'(1));
        chk("resolve_bits",  128'(io_deq_bits),  128'(mk(8'h0c, 12'h008)));
        io_deq_ready = 1'b1;
        tick();
        io_deq_ready = 1'b0;

        // Killed on arrival: occupies a slot one cycle, never presented.
        io_enq_valid    = 1'b1;
        enq_s           = mk(8'h10, 12'h010);
        mispredict_mask = 12'h010;
        tick();
        io_enq_valid    = 1'b0;
        mispredict_mask = '0;
        #1;
        chk("arrive_kill_count", 128'(io_count),     128'(1));
        chk("arrive_kill_valid", 128'(io_deq_valid), 128'(0));
        tick();
        chk("arrive_kill_gone", 128'(io_count), 128'(0));

        // Flush with a concurrent enqueue.
        io_enq_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            enq_s = mk(8'(8'h21 + i), 12'h0);
            tick();
        end
        enq_s    = mk(8'h24, 12'h0);
        io_flush = 1'b1;
        #1;
        chk("flush_cycle_valid", 128'(io_deq_valid), 128'(0));
        tick();
        io_flush     = 1'b0;
        io_enq_valid = 1'b0;
        #1;
        chk("flush_count", 128'(io_count),     128'(0));
        chk("flush_valid", 128'(io_deq_valid), 128'(0));
        tick();
        chk("flush_no_ghost", 128'(io_count), 128'(0));
        io_enq_valid = 1'b1;
        enq_s = mk(8'h31, 12'h0);
        tick();
        io_enq_valid = 1'b0;
        #1;
        chk("post_flush_bits", 128'(io_deq_bits), 128'(mk(8'h31, 12'h0)));
        io_deq_ready = 1'b1;
        tick();
        io_deq_ready = 1'b0;

        // Asynchronous reset between edges with two entries queued.
        io_enq_valid = 1'b1;
        enq_s = mk(8'h41, 12'h0);
        tick();
        enq_s = mk(8'h42, 12'h0);
        tick();
        io_enq_valid = 1'b0;
        #1;
        chk("pre_areset_count", 128'(io_count),     128'(2));
        chk("pre_areset_valid", 128'(io_deq_valid), 128'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("areset_valid",     128'(io_deq_valid), 128'(0));
        chk("areset_count",     128'(io_count),     128'(0));
        chk("areset_enq_ready", 128'(io_enq_ready), 128'(1));
        tick();
        reset = 1'b1;
        tick();
        chk("post_areset_count", 128'(io_count),     128'(0));
        chk("post_areset_valid", 128'(io_deq_valid), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
